// File: rtl/dmem_pkg.sv
// dmem_pkg: shared states, widths and address check for the data-memory responder
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int BE_W = 4;
  function automatic logic addr_err(input logic [ADDR_W-1:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[ADDR_W-1:2]} >= depth);
  endfunction
endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: single-port byte-enable word RAM with registered read
module dmem_ram
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW = $clog2(DEPTH_WORDS)
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [BE_W-1:0]   be_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem [DEPTH_WORDS];
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int i = 0; i < BE_W; i++)
        if (we_i && be_i[i]) mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      rdata_o <= mem[addr_i];
    end
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency valid/ready responder in front of the data RAM
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic [BE_W-1:0]   req_be_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o
);
  localparam int AW = $clog2(DEPTH_WORDS);
  state_e state, state_n;
  logic [3:0] cnt;
  logic wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0] be_q;
  logic idle, accept, access, cur_wr, cur_err, q_err;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata, ram_rdata;
  logic [BE_W-1:0] cur_be;
  assign idle = state == IDLE;
  assign req_ready_o = idle;
  assign accept = req_valid_i && idle;
  // with zero latency the access happens on the accept edge, straight from the inputs
  assign cur_wr = idle ? req_write_i : wr_q;
  assign cur_addr = idle ? req_addr_i : addr_q;
  assign cur_wdata = idle ? req_wdata_i : wdata_q;
  assign cur_be = idle ? req_be_i : be_q;
  assign access = (accept && LATENCY == 0) || (state == WAIT && cnt == 4'd1);
  assign cur_err = addr_err(cur_addr, unsigned'(DEPTH_WORDS));
  assign q_err = addr_err(addr_q, unsigned'(DEPTH_WORDS));
  dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk_i   (clk_i),
    .en_i    (access),
    .we_i    (cur_wr && !cur_err),
    .be_i    (cur_be),
    .addr_i  (cur_addr[AW+1:2]),
    .wdata_i (cur_wdata),
    .rdata_o (ram_rdata)
  );
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    state_n = idle ? (accept ? (LATENCY == 0 ? RESP : WAIT) : IDLE)
            : state == WAIT ? (cnt == 4'd1 ? RESP : WAIT)
            : (rsp_valid_o && rsp_ready_i) ? IDLE : state;
  end
  // the first RESP cycle waits for the registered RAM read, then the response is presented
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt <= '0;
      wr_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      be_q <= '0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o <= 1'b0;
    end else begin
      if (accept) begin
        cnt <= 4'(LATENCY);
        wr_q <= req_write_i;
        addr_q <= req_addr_i;
        wdata_q <= req_wdata_i;
        be_q <= req_be_i;
      end else if (state == WAIT) cnt <= cnt - 4'd1;
      if (state == RESP && !rsp_valid_o) begin
        rsp_valid_o <= 1'b1;
        rsp_err_o <= q_err;
        rsp_rdata_o <= (wr_q || q_err) ? '0 : ram_rdata;
      end else if (rsp_valid_o && rsp_ready_i) begin
        rsp_valid_o <= 1'b0;
        rsp_rdata_o <= '0;
        rsp_err_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized and directed checks of two responders (latency 2 and 0)
module tb_dmem_responder;
  logic clk = 1'b0, rst_i = 1'b0, sel = 1'b0;
  logic req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0] req_be = '0;
  logic rdy2, val2, err2, rdy0, val0, err0;
  logic [31:0] rdata2, rdata0;
  logic cur_ready, cur_valid, cur_err;
  logic [31:0] cur_rdata;
  int checks = 0, failures = 0;
  logic [31:0] ref_mem [2][256];
  logic [31:0] rd, xrd;
  logic er, xer, ok;
  int lat;
  time t0, t1, t2;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_lat2 (
    .clk_i(clk), .rst_i(rst_i), .req_valid_i(req_valid && !sel), .req_ready_o(rdy2),
    .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .rsp_valid_o(val2), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rdata2), .rsp_err_o(err2));
  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) u_lat0 (
    .clk_i(clk), .rst_i(rst_i), .req_valid_i(req_valid && sel), .req_ready_o(rdy0),
    .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .rsp_valid_o(val0), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rdata0), .rsp_err_o(err0));

  assign cur_ready = sel ? rdy0 : rdy2;
  assign cur_valid = sel ? val0 : val2;
  assign cur_rdata = sel ? rdata0 : rdata2;
  assign cur_err = sel ? err0 : err2;

  function automatic int lat_of(input logic s);
    return s ? 0 : 2;
  endfunction

  // reference: word array per responder, errors leave it untouched
  function automatic void model(input logic s, w, input logic [31:0] a, d, input logic [3:0] be,
                                output logic [31:0] x_rd, output logic x_er);
    x_er = (a % 4 != 0) || (a / 4 >= 256);
    x_rd = '0;
    if (!x_er) begin
      if (w) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) ref_mem[s][a / 4][8*i +: 8] = d[8*i +: 8];
      end else x_rd = ref_mem[s][a / 4];
    end
  endfunction

  task automatic xact(input logic w, input logic [31:0] a, d, input logic [3:0] be, input int hold,
                      output logic [31:0] o_rd, x_rd, output logic o_er, x_er,
                      output int o_lat, output logic o_ok, output time t_acc);
    model(sel, w, a, d, be, x_rd, x_er);
    o_ok = 1'b1; o_lat = -1; o_rd = '0; o_er = 1'b0;
    @(negedge clk);
    if (!cur_ready) o_ok = 1'b0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
    @(posedge clk); t_acc = $time; #1;
    req_valid = 1'($urandom_range(0, 1)); req_write = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
    for (int i = 1; i <= 40 && o_lat < 0; i++) begin
      @(posedge clk); #1;
      if (cur_valid) o_lat = i;
      else if (cur_ready) o_ok = 1'b0;
    end
    if (o_lat > 0) begin
      o_rd = cur_rdata; o_er = cur_err;
      if (cur_ready) o_ok = 1'b0;
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        if (!cur_valid || cur_rdata !== o_rd || cur_err !== o_er || cur_ready) o_ok = 1'b0;
      end
      req_valid = 1'b0; rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      if (cur_valid || !cur_ready) o_ok = 1'b0;
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s); #1;
      checks++; if (cur_ready !== 1'b1) begin failures++; $display("FAIL reset_ready sel=%0d got=%b exp=1", s, cur_ready); end
      checks++; if (cur_valid !== 1'b0) begin failures++; $display("FAIL reset_valid sel=%0d got=%b exp=0", s, cur_valid); end
      checks++; if (cur_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata sel=%0d got=%h exp=0", s, cur_rdata); end
      checks++; if (cur_err !== 1'b0) begin failures++; $display("FAIL reset_err sel=%0d got=%b exp=0", s, cur_err); end
    end
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
    @(posedge clk); #1;
    checks++; if (rdy2 !== 1'b1 || rdy0 !== 1'b1) begin failures++; $display("FAIL release_ready got=%b%b exp=11", rdy2, rdy0); end
  endtask

  task automatic init_mem();
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      for (int w = 0; w < 16; w++) xact(1'b1, 32'(w * 4), 32'h0, 4'hF, 0, rd, xrd, er, xer, lat, ok, t0);
    end
  endtask

  task automatic test_store_load();
    sel = 1'b0;
    xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, xrd, er, xer, lat, ok, t0);
    checks++; if (lat !== 3) begin failures++; $display("FAIL store_latency got=%0d exp=3", lat); end
    checks++; if (rd !== 32'h0 || er !== 1'b0) begin failures++; $display("FAIL store_rsp got=%h/%b exp=0/0", rd, er); end
    xact(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, xrd, er, xer, lat, ok, t0);
    checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin failures++; $display("FAIL load_after_store got=%h/%b exp=deadbeef/0", rd, er); end
  endtask

  task automatic test_byte_enable();
    sel = 1'b0;
    xact(1'b1, 32'h10, 32'h000000AA, 4'h1, 0, rd, xrd, er, xer, lat, ok, t0);
    xact(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 0, rd, xrd, er, xer, lat, ok, t0);
    checks++; if (er !== 1'b0 || rd !== 32'h0) begin failures++; $display("FAIL be_zero_rsp got=%h/%b exp=0/0", rd, er); end
    xact(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, xrd, er, xer, lat, ok, t0);
    checks++; if (rd !== 32'hDEADBEAA) begin failures++; $display("FAIL byte_enable got=%h exp=deadbeaa", rd); end
  endtask

  task automatic test_errors();
    sel = 1'b0;
    xact(1'b0, 32'h13, 32'h0, 4'h0, 0, rd, xrd, er, xer, lat, ok, t0);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL misaligned got=%h/%b exp=0/1", rd, er); end
    xact(1'b1, 32'h400, 32'h55, 4'hF, 0, rd, xrd, er, xer, lat, ok, t0);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL out_of_range got=%h/%b exp=0/1", rd, er); end
    xact(1'b0, 32'h0, 32'h0, 4'h0, 0, rd, xrd, er, xer, lat, ok, t0);
    checks++; if (rd !== 32'h0 || er !== 1'b0) begin failures++; $display("FAIL no_alias got=%h/%b exp=0/0", rd, er); end
  endtask

  task automatic test_backpressure();
    sel = 1'b0;
    xact(1'b0, 32'h10, 32'h0, 4'h0, 5, rd, xrd, er, xer, lat, ok, t0);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL backpressure_handshake got=%b exp=1", ok); end
    checks++; if (rd !== 32'hDEADBEAA) begin failures++; $display("FAIL backpressure_data got=%h exp=deadbeaa", rd); end
  endtask

  task automatic test_back_to_back();
    sel = 1'b1;
    xact(1'b1, 32'h10, 32'hCAFEF00D, 4'hF, 0, rd, xrd, er, xer, lat, ok, t0);
    xact(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, xrd, er, xer, lat, ok, t0);
    checks++; if (lat !== 1) begin failures++; $display("FAIL lat0_latency got=%0d exp=1", lat); end
    checks++; if (rd !== 32'hCAFEF00D) begin failures++; $display("FAIL lat0_load got=%h exp=cafef00d", rd); end
    xact(1'b0, 32'h14, 32'h0, 4'h0, 0, rd, xrd, er, xer, lat, ok, t1);
    xact(1'b0, 32'h18, 32'h0, 4'h0, 0, rd, xrd, er, xer, lat, ok, t2);
    checks++; if (t1 - t0 != 30 || t2 - t1 != 30) begin failures++; $display("FAIL lat0_period got=%0d,%0d exp=30,30", t1 - t0, t2 - t1); end
    sel = 1'b0;
    xact(1'b0, 32'h14, 32'h0, 4'h0, 0, rd, xrd, er, xer, lat, ok, t0);
    xact(1'b0, 32'h18, 32'h0, 4'h0, 0, rd, xrd, er, xer, lat, ok, t1);
    checks++; if (t1 - t0 != 50) begin failures++; $display("FAIL lat2_period got=%0d exp=50", t1 - t0); end
  endtask

  task automatic test_reset_mid();
    sel = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #2;
    checks++; if (rdy2 !== 1'b0) begin failures++; $display("FAIL wait_ready got=%b exp=0", rdy2); end
    rst_i = 1'b0; #1;
    checks++; if (rdy2 !== 1'b1 || val2 !== 1'b0 || rdata2 !== 32'h0 || err2 !== 1'b0) begin
      failures++; $display("FAIL reset_mid_outputs got=%b/%b/%h/%b exp=1/0/0/0", rdy2, val2, rdata2, err2);
    end
    @(negedge clk); rst_i = 1'b1;
    xact(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, xrd, er, xer, lat, ok, t0);
    checks++; if (rd !== 32'h0 || er !== 1'b0) begin failures++; $display("FAIL reset_discard got=%h/%b exp=0/0", rd, er); end
  endtask

  task automatic test_random();
    logic w;
    logic [31:0] a, d;
    int r;
    for (int n = 0; n < 40; n++) begin
      sel = 1'($urandom_range(0, 1));
      w = 1'($urandom);
      d = $urandom;
      r = $urandom_range(0, 9);
      a = 32'($urandom_range(0, 15)) * 4;
      if (r == 8) a = a | 32'($urandom_range(1, 3));
      if (r == 9) a = ($urandom | 32'h400) & ~32'h3;
      xact(w, a, d, 4'($urandom), $urandom_range(0, 3), rd, xrd, er, xer, lat, ok, t0);
      checks++; if (rd !== xrd) begin failures++; $display("FAIL rand_rdata n=%0d addr=%h got=%h exp=%h", n, a, rd, xrd); end
      checks++; if (er !== xer) begin failures++; $display("FAIL rand_err n=%0d addr=%h got=%b exp=%b", n, a, er, xer); end
      checks++; if (lat !== lat_of(sel) + 1) begin failures++; $display("FAIL rand_latency n=%0d got=%0d exp=%0d", n, lat, lat_of(sel) + 1); end
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL rand_handshake n=%0d got=%b exp=1", n, ok); end
    end
  endtask

  initial begin
    test_reset();
    init_mem();
    test_store_load();
    test_byte_enable();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
